fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one FIFO write port among NUM_REQ producers, such as modular-multiplier result lanes in the Paillier datapath. Each grant is locked for one whole operand burst of WORDS_PER_OP words, so the multi-word big integers from different producers never interleave in the FIFO. The block sits directly in front of the FIFO write port and drives its wr_en and wr_data; it consumes the FIFO's full flag.

---
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter that shares one FIFO write port among NUM_REQ producers.
// Optional macro ARB_TIMEOUT_EN aborts a burst whose owner stops presenting words.
module fifo_wr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int WORDS_PER_OP   = 16,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int GRANT_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  input  logic                          fifo_wr_full,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          busy,
  output logic                          burst_done,
  output logic                          err_timeout
);

  localparam int BEAT_W = (WORDS_PER_OP > 1) ? $clog2(WORDS_PER_OP) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_reg, state_next;
  logic [GRANT_W-1:0]    grant_reg, grant_next;
  logic [GRANT_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [GRANT_W-1:0]    pick_idx, scan_idx;
  logic [BEAT_W-1:0]     beat_cnt_reg, beat_cnt_next;
  logic                  pick_found, owner_valid, beat, last_beat;
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  if (NUM_REQ < 1 || NUM_REQ > 16 || WORDS_PER_OP < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: parameter out of range");
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign owner_valid  = req_valid[grant_reg];
  assign beat         = (state_reg == BURST) && owner_valid && !fifo_wr_full;
  assign last_beat    = (beat_cnt_reg == BEAT_W'(WORDS_PER_OP - 1));
  assign fifo_wr_data = req_word[grant_reg];
  assign grant_id     = grant_reg;
  assign busy         = (state_reg == BURST);

  // Scan starts one past the previous owner so every producer gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = rr_ptr_reg;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = (scan_idx == GRANT_W'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [STALL_W-1:0] stall_cnt_reg, stall_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_reg <= '0;
    else     stall_cnt_reg <= stall_cnt_next;
  end
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;
    req_ready     = '0;
    fifo_wr_en    = 1'b0;
    burst_done    = 1'b0;
`ifdef ARB_TIMEOUT_EN
    stall_cnt_next = stall_cnt_reg;
    err_timeout    = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          state_next = BURST;
        end
`ifdef ARB_TIMEOUT_EN
        stall_cnt_next = '0;
`endif
      end
      BURST: begin
        req_ready[grant_reg] = !fifo_wr_full;
        if (beat) begin
          fifo_wr_en = 1'b1;
`ifdef ARB_TIMEOUT_EN
          stall_cnt_next = '0;
`endif
          if (last_beat) begin
            burst_done    = 1'b1;
            beat_cnt_next = '0;
            rr_ptr_next   = grant_reg;
            state_next    = IDLE;
          end else begin
            beat_cnt_next = beat_cnt_reg + 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // Only owner-side starvation counts; a full FIFO neither advances nor clears the count.
        else if (!owner_valid) begin
          if (stall_cnt_reg == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            err_timeout    = 1'b1;
            beat_cnt_next  = '0;
            rr_ptr_next    = grant_reg;
            stall_cnt_next = '0;
            state_next     = IDLE;
          end else begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
          end
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= GRANT_W'(NUM_REQ - 1);
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter (4 producers, 16-word bursts).
module tb_fifo_wr_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int WPO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_wr_full;
  logic [1:0]      grant_id;
  logic            busy, burst_done, err_timeout;

  fifo_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .WORDS_PER_OP(WPO), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .grant_id(grant_id), .busy(busy),
    .burst_done(burst_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] valid;
    logic       full;
    logic [3:0] rdy;
    logic       en;
    logic [1:0] g;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic [3:0] val, input logic full,
                     input logic [3:0] rdy, input logic en, input logic [1:0] g,
                     input logic bsy, input logic done, input logic err);
    vec_t v;
    v = '{rst: r, valid: val, full: full, rdy: rdy, en: en, g: g,
          busy: bsy, done: done, err: err};
    vecs.push_back(v);
  endtask

  // One arbitration cycle followed by an uninterrupted WPO-word burst for owner g.
  task automatic burst_vecs(input int g, input logic [3:0] val, input logic [1:0] prev_g);
    add(1'b0, val, 1'b0, 4'b0000, 1'b0, prev_g, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < WPO; k++)
      add(1'b0, val, 1'b0, 4'(1 << g), 1'b1, 2'(g), 1'b1, (k == WPO - 1), 1'b0);
  endtask

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, n, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    logic [DW-1:0] exp_data;

    // Reset state observed with idle inputs.
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    // Single requester 2: grant one cycle after valid, 16 ordered words, busy drops after.
    burst_vecs(2, 4'b0100, 2'd0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    // Reset, then all valid: rotation 0,1,2,3 with no interleaving.
    add(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    burst_vecs(0, 4'b1111, 2'd0);
    burst_vecs(1, 4'b1111, 2'd0);
    burst_vecs(2, 4'b1111, 2'd1);
    burst_vecs(3, 4'b1111, 2'd2);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    // Owner 1 stalled by a full FIFO for 10 cycles after 5 beats.
    add(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++)
      add(1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 5; k < WPO; k++)
      add(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, (k == WPO - 1), 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    // Owner 3 reset mid-burst at beat 8; next arbitration with 1001 grants 0.
    add(1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      add(1'b0, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    add(1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    burst_vecs(0, 4'b1001, 2'd0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    // Owner 2 valid every other cycle: beats only when valid, done on the 16th.
    add(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < WPO; k++) begin
      add(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
      add(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, (k == WPO - 1), 1'b0);
    end
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
`ifdef ARB_TIMEOUT_EN
    // Owner 0 drops valid after 3 beats: abort on the 8th idle cycle, then grant 1.
    add(1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      add(1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      add(1'b0, 4'b0010, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, (k == 7));
    add(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
`endif

    rst = 1'b1; req_valid = '0; fifo_wr_full = 1'b0; req_data = '0;
    repeat (2) @(posedge clk);
    #1;

    for (int n = 0; n < vecs.size(); n++) begin
      v = vecs[n];
      rst          = v.rst;
      req_valid    = v.valid;
      fifo_wr_full = v.full;
      for (int p = 0; p < NR; p++)
        req_data[p*DW +: DW] = DW'((p << 12) | (n & 'hfff));
      #4;
      exp_data = DW'((int'(v.g) << 12) | (n & 'hfff));
      chk("req_ready",   n, 32'(req_ready),   32'(v.rdy));
      chk("fifo_wr_en",  n, 32'(fifo_wr_en),  32'(v.en));
      chk("grant_id",    n, 32'(grant_id),    32'(v.g));
      chk("busy",        n, 32'(busy),        32'(v.busy));
      chk("burst_done",  n, 32'(burst_done),  32'(v.done));
      chk("err_timeout", n, 32'(err_timeout), 32'(v.err));
      if (v.en) chk("fifo_wr_data", n, 32'(fifo_wr_data), 32'(exp_data));
      $display("vec %0d rst=%0b valid=%b full=%0b grant=%0d wr_en=%0b data=%h done=%0b err=%0b",
               n, v.rst, v.valid, v.full, grant_id, fifo_wr_en, fifo_wr_data, burst_done, err_timeout);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
